game_io_frontend: RTL and testbench

Parametrised board front-end for the alien guessing game. It sits between the raw board pins and the `top` game core. It conditions the active-low push-buttons into clean single-cycle press pulses, and runs a registered display-view state machine. That machine selects between the status view (NumGames, RoundNumber, Zood, Znarly) and a debug master-pattern view. It also drives a blinking GameWon LED. It replaces ad-hoc combinational pin wiring with a synchronised, debounced, width-generic block.

---
 rtl/game_io_frontend.sv | 173 +++++++++++++++++
 tb/tb_game_io_frontend.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/game_io_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : game_io_frontend
//  Purpose  : Board front-end for the alien guessing game. Synchronises and
//             debounces the active-low keys into press pulses, selects the
//             status or master-pattern seven-segment view, and blinks the
//             GameWon LED.
//  Revision : 1.0  initial release
// ============================================================================
module game_io_frontend #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_DIGITS      = 8,
  parameter int SHAPES          = 4,
  parameter int SHAPE_W         = 3,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_KEYS-1:0]       key_n,
  input  logic                      debug,
  input  logic                      show_master,
  input  logic                      game_won,
  input  logic [3:0]                num_games,
  input  logic [3:0]                round_number,
  input  logic [3:0]                zood,
  input  logic [3:0]                znarly,
  input  logic [SHAPES*SHAPE_W-1:0] master_pattern,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       key_press,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic [NUM_DIGITS-1:0]     blank,
  output logic [7:0]                ledg
);

  localparam int             DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam int             BCW     = $clog2(BLINK_CYCLES + 1);
  localparam logic [BCW-1:0] BL_LAST = BCW'(BLINK_CYCLES - 1);

  localparam logic [0:0] ST_STATUS = 1'b0;
  localparam logic [0:0] ST_MASTER = 1'b1;

  // --------------------------------------------------------------------------
  // Key conditioning: each key has its own synchroniser and debounce counter.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic           s1;
    logic           s2;
    logic           level;
    logic           press;
    logic [DCW-1:0] cnt;

    // Synchronise, qualify a stable change, and pulse on an accepted press.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1    <= 1'b1;
        s2    <= 1'b1;
        level <= 1'b1;
        press <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= key_n[k];
        s2    <= s1;
        press <= 1'b0;
        if (s2 != level) begin
          if (cnt == DB_LAST) begin
            level <= s2;
            cnt   <= '0;
            // Only a falling level (press) pulses; releases are silent.
            press <= ~s2;
          end else begin
            cnt <= cnt + DCW'(1);
          end
        end else begin
          // Any sample matching the accepted level restarts qualification.
          cnt <= '0;
        end
      end
    end

    assign key_level[k] = level;
    assign key_press[k] = press;
  end

  // --------------------------------------------------------------------------
  // View state machine and registered display.
  // --------------------------------------------------------------------------
  logic [0:0]              state;
  logic [0:0]              next_state;
  logic [4*NUM_DIGITS-1:0] next_bcd;
  logic [NUM_DIGITS-1:0]   next_blank;
  logic [3:0]              shape_ext;

  // Next view decision from the switches sampled this cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_STATUS: if (debug && show_master)   next_state = ST_MASTER;
      ST_MASTER: if (!debug || !show_master) next_state = ST_STATUS;
      default:                               next_state = ST_STATUS;
    endcase
  end

  // Display content for the view being entered, so a switch and its
  // content land on the same edge.
  always_comb begin
    next_bcd   = '0;
    next_blank = '1;
    shape_ext  = '0;
    if (next_state == ST_MASTER) begin
      for (int i = 0; i < SHAPES; i++) begin
        shape_ext                = '0;
        shape_ext[SHAPE_W-1:0]   = master_pattern[i*SHAPE_W +: SHAPE_W];
        next_bcd[i*4 +: 4]       = shape_ext;
        next_blank[i]            = 1'b0;
      end
    end else begin
      next_bcd[3:0]   = num_games;
      next_bcd[7:4]   = round_number;
      next_bcd[11:8]  = zood;
      next_bcd[15:12] = znarly;
      next_blank[3:0] = 4'b0000;
    end
  end

  // Register the view state and the digit outputs together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_STATUS;
      bcd   <= '0;
      blank <= '1;
    end else begin
      state <= next_state;
      bcd   <= next_bcd;
      blank <= next_blank;
    end
  end

  // --------------------------------------------------------------------------
  // GameWon blink: lights immediately on the rising level, then toggles
  // every BLINK_CYCLES cycles while the level is held.
  // --------------------------------------------------------------------------
  logic           blink;
  logic           won_seen;
  logic [BCW-1:0] blink_cnt;

  // Blink generator restarted on each fresh game_won assertion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink     <= 1'b0;
      won_seen  <= 1'b0;
      blink_cnt <= '0;
    end else if (!game_won) begin
      blink     <= 1'b0;
      won_seen  <= 1'b0;
      blink_cnt <= '0;
    end else if (!won_seen) begin
      blink     <= 1'b1;
      won_seen  <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BL_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BCW'(1);
    end
  end

  assign ledg = {state == ST_MASTER, 6'b000000, blink};

endmodule
`default_nettype wire

// File: tb/tb_game_io_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_io_frontend
//  Purpose  : Directed self-checking bench for game_io_frontend.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_game_io_frontend;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic        debug = 1'b0;
  logic        show_master = 1'b0;
  logic        game_won = 1'b0;
  logic [3:0]  num_games = 4'd3;
  logic [3:0]  round_number = 4'd1;
  logic [3:0]  zood = 4'd2;
  logic [3:0]  znarly = 4'd0;
  logic [11:0] master_pattern = 12'b101_011_110_001;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic [31:0] bcd;
  logic [7:0]  blank;
  logic [7:0]  ledg;

  int checks = 0;
  int failures = 0;

  game_io_frontend #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .NUM_DIGITS(8),
    .SHAPES(4), .SHAPE_W(3), .BLINK_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .debug(debug),
    .show_master(show_master), .game_won(game_won), .num_games(num_games),
    .round_number(round_number), .zood(zood), .znarly(znarly),
    .master_pattern(master_pattern), .key_level(key_level),
    .key_press(key_press), .bcd(bcd), .blank(blank), .ledg(ledg)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    // Build up non-reset state: master view plus lit GameWon LED.
    tick();
    reset = 1'b0;
    debug = 1'b1; show_master = 1'b1; game_won = 1'b1;
    tick(); tick();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (bcd !== 32'h0) begin failures++; $display("FAIL reset_bcd got %h want %h", bcd, 32'h0); end
    checks++; if (blank !== 8'hFF) begin failures++; $display("FAIL reset_blank got %h want %h", blank, 8'hFF); end
    checks++; if (ledg !== 8'h00) begin failures++; $display("FAIL reset_ledg got %h want %h", ledg, 8'h00); end
    checks++; if (key_level !== 4'hF) begin failures++; $display("FAIL reset_key_level got %h want %h", key_level, 4'hF); end
    checks++; if (key_press !== 4'h0) begin failures++; $display("FAIL reset_key_press got %h want %h", key_press, 4'h0); end
    debug = 1'b0; show_master = 1'b0; game_won = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bcd[15:0] !== 16'h0213) begin failures++; $display("FAIL first_status_bcd got %h want %h", bcd[15:0], 16'h0213); end
    checks++; if (bcd[31:16] !== 16'h0000) begin failures++; $display("FAIL first_status_hi got %h want %h", bcd[31:16], 16'h0000); end
    checks++; if (blank !== 8'hF0) begin failures++; $display("FAIL first_status_blank got %h want %h", blank, 8'hF0); end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_press;
    logic       exp_level;
    key_n = 4'b1101;
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_press = (n == 6) ? 4'b0010 : 4'b0000;
      exp_level = (n >= 6) ? 1'b0 : 1'b1;
      checks++; if (key_press !== exp_press) begin failures++; $display("FAIL clean_press edge %0d got %b want %b", n, key_press, exp_press); end
      checks++; if (key_level[1] !== exp_level) begin failures++; $display("FAIL clean_level edge %0d got %b want %b", n, key_level[1], exp_level); end
    end
    key_n = 4'hF;
    for (int n = 1; n <= 9; n++) begin
      tick();
      checks++; if (key_press !== 4'b0000) begin failures++; $display("FAIL release_no_pulse edge %0d got %b want %b", n, key_press, 4'b0000); end
    end
    checks++; if (key_level !== 4'hF) begin failures++; $display("FAIL release_level got %h want %h", key_level, 4'hF); end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_press;
    key_n = 4'b1011;
    for (int n = 1; n <= 14; n++) begin
      tick();
      exp_press = (n == 10) ? 4'b0100 : 4'b0000;
      checks++; if (key_press !== exp_press) begin failures++; $display("FAIL bounce_press edge %0d got %b want %b", n, key_press, exp_press); end
      if (n == 3) key_n = 4'b1111;
      if (n == 4) key_n = 4'b1011;
    end
    key_n = 4'hF;
    for (int n = 0; n < 9; n++) tick();
    checks++; if (key_level !== 4'hF) begin failures++; $display("FAIL bounce_release_level got %h want %h", key_level, 4'hF); end
  endtask

  task automatic test_master_view();
    // show_master alone must not leave the status view.
    debug = 1'b0; show_master = 1'b1;
    tick(); tick();
    checks++; if (ledg[7] !== 1'b0) begin failures++; $display("FAIL nodebug_led7 got %b want %b", ledg[7], 1'b0); end
    checks++; if (bcd[15:0] !== 16'h0213) begin failures++; $display("FAIL nodebug_bcd got %h want %h", bcd[15:0], 16'h0213); end
    debug = 1'b1;
    tick();
    checks++; if (bcd[15:0] !== 16'h5361) begin failures++; $display("FAIL master_bcd got %h want %h", bcd[15:0], 16'h5361); end
    checks++; if (bcd[31:16] !== 16'h0000) begin failures++; $display("FAIL master_hi got %h want %h", bcd[31:16], 16'h0000); end
    checks++; if (blank !== 8'hF0) begin failures++; $display("FAIL master_blank got %h want %h", blank, 8'hF0); end
    checks++; if (ledg[7] !== 1'b1) begin failures++; $display("FAIL master_led7 got %b want %b", ledg[7], 1'b1); end
    // Content follows the live pattern while in master view.
    master_pattern = 12'b111_000_010_100;
    tick();
    checks++; if (bcd[15:0] !== 16'h7024) begin failures++; $display("FAIL master_update got %h want %h", bcd[15:0], 16'h7024); end
    debug = 1'b0;
    tick();
    checks++; if (bcd[15:0] !== 16'h0213) begin failures++; $display("FAIL back_status_bcd got %h want %h", bcd[15:0], 16'h0213); end
    checks++; if (ledg[7] !== 1'b0) begin failures++; $display("FAIL back_status_led7 got %b want %b", ledg[7], 1'b0); end
    show_master = 1'b0;
    num_games = 4'd9; znarly = 4'd7;
    tick();
    checks++; if (bcd[15:0] !== 16'h7219) begin failures++; $display("FAIL status_update got %h want %h", bcd[15:0], 16'h7219); end
  endtask

  task automatic test_blink();
    logic exp_blink;
    game_won = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_blink = (((n - 1) / 3) % 2) == 0;
      checks++; if (ledg[0] !== exp_blink) begin failures++; $display("FAIL blink edge %0d got %b want %b", n, ledg[0], exp_blink); end
      checks++; if (ledg[6:1] !== 6'b0) begin failures++; $display("FAIL blink_unused edge %0d got %b want %b", n, ledg[6:1], 6'b0); end
    end
    game_won = 1'b0;
    tick();
    checks++; if (ledg[0] !== 1'b0) begin failures++; $display("FAIL blink_off got %b want %b", ledg[0], 1'b0); end
    // Restart is immediate on a fresh rise.
    game_won = 1'b1;
    tick();
    checks++; if (ledg[0] !== 1'b1) begin failures++; $display("FAIL blink_restart got %b want %b", ledg[0], 1'b1); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (ledg[0] !== 1'b0) begin failures++; $display("FAIL blink_reset got %b want %b", ledg[0], 1'b0); end
    game_won = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_press;
    key_n = 4'b0110;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_press = (n == 6) ? 4'b1001 : 4'b0000;
      checks++; if (key_press !== exp_press) begin failures++; $display("FAIL simul_press edge %0d got %b want %b", n, key_press, exp_press); end
    end
    checks++; if (key_level !== 4'b0110) begin failures++; $display("FAIL simul_level got %b want %b", key_level, 4'b0110); end
    key_n = 4'hF;
    for (int n = 0; n < 9; n++) tick();
    // Reset with key 0 two counts into qualification.
    key_n = 4'b1110;
    for (int n = 1; n <= 4; n++) tick();
    reset = 1'b1;
    #1;
    checks++; if (key_press !== 4'b0000) begin failures++; $display("FAIL middeb_press got %b want %b", key_press, 4'b0000); end
    tick(); tick();
    checks++; if (key_level !== 4'hF) begin failures++; $display("FAIL middeb_level got %h want %h", key_level, 4'hF); end
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_press = (n == 6) ? 4'b0001 : 4'b0000;
      checks++; if (key_press !== exp_press) begin failures++; $display("FAIL requal_press edge %0d got %b want %b", n, key_press, exp_press); end
    end
    key_n = 4'hF;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_master_view();
    test_blink();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
